// File: rtl/spi_master_arb.sv
// SPI master shared by NUM_REQ requesters through a round-robin arbiter.
// One DATA_W frame per grant, full duplex, response tagged with the requester index.
module spi_master_arb #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       rsp_valid_o,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       busy_o,
  output logic                       sclk_o,
  output logic                       mosi_o,
  input  logic                       miso_i,
  output logic [NUM_REQ-1:0]         ss_no
);

  localparam int LAST_HP  = 2*DATA_W - 1;
  localparam int HC_W     = $clog2(2*DATA_W);
  // IDLE always spends one cycle before a grant, so it counts as part of the gap
  localparam int GAP_CYC  = GAP*CLK_DIV - 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int CNT_W    = $clog2(GAP*CLK_DIV + CLK_DIV) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [HC_W-1:0]   hcnt;
  logic [ID_W-1:0]   ptr, win, id;
  logic              found, fire, tick, frame_end;
  logic              lead_edge, trail_edge, last_trail, sample, shift_out;
  logic [DATA_W-1:0] win_data, tx_sr, rx_sr;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid_i[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign win_data    = req_data_i[int'(win)*DATA_W +: DATA_W];
  assign req_ready_o = (state == S_IDLE && found && rstn_i) ? (NUM_REQ'(1) << win) : '0;
  assign fire        = |req_ready_o;
  assign busy_o      = (state != S_IDLE);

  // Half-period timer; SETUP expiry is sclk edge 1, SHIFT expiries are edges 2..2*DATA_W
  assign tick       = (cnt == CNT_W'(CLK_DIV - 1));
  assign frame_end  = (state == S_HOLD) && tick;
  assign lead_edge  = (state == S_SETUP && tick) ||
                      (state == S_SHIFT && tick && hcnt != HC_W'(LAST_HP) && hcnt[0]);
  assign trail_edge = (state == S_SHIFT) && tick && hcnt != HC_W'(LAST_HP) && !hcnt[0];
  assign last_trail = trail_edge && (hcnt == HC_W'(LAST_HP - 1));
  assign sample     = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_out  = (CPHA != 0) ? lead_edge : (trail_edge && !last_trail);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fire) state_nxt = S_SETUP;
      S_SETUP: if (tick) state_nxt = S_SHIFT;
      S_SHIFT: if (tick && hcnt == HC_W'(LAST_HP)) state_nxt = S_HOLD;
      S_HOLD:  if (tick) state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (cnt == CNT_W'(GAP_LAST)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hcnt        <= '0;
      ptr         <= '0;
      id          <= '0;
      sclk_o      <= 1'(CPOL);
      mosi_o      <= 1'b0;
      ss_no       <= '1;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE || (tick && state != S_GAP))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state == S_SETUP)
        hcnt <= '0;
      else if (state == S_SHIFT && tick)
        hcnt <= hcnt + HC_W'(1);
      if (lead_edge || trail_edge)
        sclk_o <= ~sclk_o;
      rsp_valid_o <= frame_end;
      if (fire) begin
        id    <= win;
        ptr   <= ID_W'((int'(win) + 1) % NUM_REQ);
        ss_no <= ~(NUM_REQ'(1) << win);
        if (CPHA == 0)
          mosi_o <= win_data[DATA_W-1];
      end else if (shift_out) begin
        mosi_o <= tx_sr[DATA_W-1];
      end
      if (frame_end) begin
        ss_no      <= '1;
        mosi_o     <= 1'b0;
        rsp_id_o   <= id;
        rsp_data_o <= rx_sr;
      end
    end
  end

  // Shift registers carry only data; every frame fully overwrites them
  always_ff @(posedge clk_i) begin
    if (fire)
      tx_sr <= (CPHA != 0) ? win_data : (win_data << 1);
    else if (shift_out)
      tx_sr <= tx_sr << 1;
    if (sample)
      rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
  end

endmodule
